// File: rtl/phase_sequencer.sv
// phase_sequencer: timed IDLE->A->B->C sequencer with a CLK_HZ/TICK_HZ prescaler, loop and abort.
// Optional macro SEQ_PAUSE_EN adds a pause input that freezes all timing while busy.
module phase_sequencer #(
  parameter int CLK_HZ = 100_000_000,
  parameter int TICK_HZ = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       loop,
  input  logic [7:0] dur_a,
  input  logic [7:0] dur_b,
  input  logic [7:0] dur_c,
`ifdef SEQ_PAUSE_EN
  input  logic       pause,
`endif
  output logic       busy,
  output logic [1:0] phase,
  output logic       tick,
  output logic       done
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PH_A = 2'd1;
  localparam logic [1:0] PH_B = 2'd2;
  localparam logic [1:0] PH_C = 2'd3;
  logic [PW-1:0] presc;
  logic [7:0] tcnt, da, db, dc, cur_dur, last;
  logic hold, wrap, fin;
`ifdef SEQ_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif
  // a zero duration behaves as one tick
  always_comb begin
    cur_dur = (phase == PH_A) ? da : (phase == PH_B) ? db : dc;
    last = (cur_dur == 8'd0) ? 8'd0 : cur_dur - 8'd1;
    wrap = busy && !hold && (presc == PW'(DIV - 1));
    fin = wrap && (tcnt == last);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= IDLE;
      busy <= 1'b0;
      tick <= 1'b0;
      done <= 1'b0;
      presc <= '0;
      tcnt <= '0;
      da <= '0;
      db <= '0;
      dc <= '0;
    end else if (!busy) begin
      tick <= 1'b0;
      done <= 1'b0;
      presc <= '0;
      tcnt <= '0;
      if (start && !abort) begin
        da <= dur_a;
        db <= dur_b;
        dc <= dur_c;
        phase <= PH_A;
        busy <= 1'b1;
      end
    end else if (abort) begin
      phase <= IDLE;
      busy <= 1'b0;
      tick <= 1'b0;
      done <= 1'b0;
      presc <= '0;
      tcnt <= '0;
    end else if (hold) begin
      tick <= 1'b0;
      done <= 1'b0;
    end else begin
      presc <= wrap ? '0 : presc + 1'b1;
      tick <= wrap;
      done <= fin && (phase == PH_C);
      if (fin) begin
        tcnt <= '0;
        phase <= (phase == PH_C) ? (loop ? PH_A : IDLE) : phase + 2'd1;
        busy <= !(phase == PH_C && !loop);
        if (phase == PH_C && loop) begin
          da <= dur_a;
          db <= dur_b;
          dc <= dur_c;
        end
      end else if (wrap) begin
        tcnt <= tcnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: directed table and hand sequences for phase_sequencer with DIV=10.
module tb_phase_sequencer;
  logic clk = 1'b0;
  logic rst, start, abort, loop;
  logic [7:0] dur_a, dur_b, dur_c;
`ifdef SEQ_PAUSE_EN
  logic pause;
`endif
  logic busy, tick, done;
  logic [1:0] phase;
  int checks = 0;
  int errors = 0;
  typedef struct {
    int cyc;
    logic [1:0] ph;
    logic bsy;
    logic dn;
    logic tk;
    logic ck_tk;
  } vec_t;
  vec_t tbl[11];
  always #5 clk = ~clk;
  phase_sequencer #(.CLK_HZ(10), .TICK_HZ(1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .loop(loop),
    .dur_a(dur_a), .dur_b(dur_b), .dur_c(dur_c),
`ifdef SEQ_PAUSE_EN
    .pause(pause),
`endif
    .busy(busy), .phase(phase), .tick(tick), .done(done)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // runs the 2/3/1 sequence from a start at cycle 0 with optional abort, restart or pause injection
  task automatic run_seq(input int ab_at, input int st_at, input int ps_at,
                         output int t_b, output int t_c, output int t_d, output int n_d, output int t_i);
    t_b = -1; t_c = -1; t_d = -1; n_d = 0; t_i = -1;
    dur_a = 8'd2; dur_b = 8'd3; dur_c = 8'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 90; c++) begin
      abort = (c == ab_at);
      if (c == st_at) begin
        start = 1'b1;
        dur_a = 8'd5; dur_b = 8'd5; dur_c = 8'd5;
      end
`ifdef SEQ_PAUSE_EN
      pause = (ps_at > 0) && (c >= ps_at) && (c < ps_at + 7);
`endif
      step();
      start = 1'b0;
      abort = 1'b0;
`ifdef SEQ_PAUSE_EN
      pause = 1'b0;
`endif
      if (phase == 2'd2 && t_b < 0) t_b = c + 1;
      if (phase == 2'd3 && t_c < 0) t_c = c + 1;
      if (phase == 2'd0 && t_i < 0) t_i = c + 1;
      if (done) begin
        n_d++;
        if (t_d < 0) t_d = c + 1;
      end
    end
  endtask
  initial begin
    int cyc, t_b, t_c, t_d, n_d, t_i, na, nb, d1, d2, gaps, badph;
    tbl[0]  = '{1,  2'd1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{10, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{11, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{12, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{20, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{21, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{50, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{51, 2'd3, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{60, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{61, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{62, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    rst = 1'b1; start = 1'b0; abort = 1'b0; loop = 1'b0;
    dur_a = '0; dur_b = '0; dur_c = '0;
`ifdef SEQ_PAUSE_EN
    pause = 1'b0;
`endif
    step();
    step();
    chk("reset_phase", phase, 0);
    chk("reset_busy", busy, 0);
    chk("reset_tick", tick, 0);
    chk("reset_done", done, 0);
    rst = 1'b0;
    step();
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_phase", phase, 0);
    chk("start_abort_busy", busy, 0);
    step();
    dur_a = 8'd2; dur_b = 8'd3; dur_c = 8'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    foreach (tbl[i]) begin
      while (cyc < tbl[i].cyc) begin
        step();
        cyc++;
      end
      chk($sformatf("basic_phase@%0d", tbl[i].cyc), phase, tbl[i].ph);
      chk($sformatf("basic_busy@%0d", tbl[i].cyc), busy, tbl[i].bsy);
      chk($sformatf("basic_done@%0d", tbl[i].cyc), done, tbl[i].dn);
      if (tbl[i].ck_tk) chk($sformatf("basic_tick@%0d", tbl[i].cyc), tick, tbl[i].tk);
    end
    step();
    run_seq(-1, -1, -1, t_b, t_c, t_d, n_d, t_i);
    chk("seq_b_start", t_b, 21);
    chk("seq_c_start", t_c, 51);
    chk("seq_done_at", t_d, 61);
    chk("seq_done_cnt", n_d, 1);
    run_seq(25, -1, -1, t_b, t_c, t_d, n_d, t_i);
    chk("abort_idle_at", t_i, 26);
    chk("abort_done_cnt", n_d, 0);
    run_seq(60, -1, -1, t_b, t_c, t_d, n_d, t_i);
    chk("abort_endc_idle_at", t_i, 61);
    chk("abort_endc_done_cnt", n_d, 0);
    run_seq(-1, 15, -1, t_b, t_c, t_d, n_d, t_i);
    chk("restart_b_start", t_b, 21);
    chk("restart_c_start", t_c, 51);
    chk("restart_done_at", t_d, 61);
`ifdef SEQ_PAUSE_EN
    run_seq(-1, -1, 30, t_b, t_c, t_d, n_d, t_i);
    chk("pause_b_start", t_b, 21);
    chk("pause_c_start", t_c, 58);
    chk("pause_done_at", t_d, 68);
    chk("pause_idle_at", t_i, 68);
`endif
    dur_a = 8'd0; dur_b = 8'd1; dur_c = 8'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    na = 0; nb = 0;
    for (int c = 0; c < 100 && busy; c++) begin
      nb++;
      if (phase == 2'd1) na++;
      step();
    end
    chk("zero_dur_a_len", na, 10);
    chk("zero_dur_busy_len", nb, 30);
    dur_a = 8'd1; dur_b = 8'd1; dur_c = 8'd1;
    loop = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    d1 = -1; d2 = -1; gaps = 0; badph = 0;
    for (int c = 1; c < 70; c++) begin
      step();
      if (!busy) gaps++;
      if (done) begin
        if (phase != 2'd1) badph++;
        if (d1 < 0) d1 = c + 1;
        else if (d2 < 0) d2 = c + 1;
      end
    end
    chk("loop_first_done", d1, 31);
    chk("loop_period", d2 - d1, 30);
    chk("loop_idle_gaps", gaps, 0);
    chk("loop_phase_at_done", badph, 0);
    loop = 1'b0;
    for (int c = 0; c < 100 && busy; c++) step();
    chk("loop_exit_busy", busy, 0);
    dur_a = 8'd2; dur_b = 8'd3; dur_c = 8'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    chk("midrst_phase", phase, 0);
    chk("midrst_done", done, 0);
    rst = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("post_rst_start_phase", phase, 1);
    chk("post_rst_start_busy", busy, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/phase_sequencer.md
PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 100_000_000, giving the input clock frequency in Hz.
REQ-002 The block SHALL have parameter TICK_HZ, default 10, giving the phase-timing tick rate in Hz; DIV = CLK_HZ/TICK_HZ, with DIV >= 2 required.
REQ-003 clk  input  1  system clock, single clock domain, all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  request to run one sequence; level-sampled each cycle.
REQ-006 abort  input  1  request to terminate the current sequence.
REQ-007 loop  input  1  when high at the end of phase C, the sequence restarts at phase A.
REQ-008 dur_a, dur_b, dur_c  input  8 each  phase durations in ticks.
REQ-009 pause  input  1  freezes timing; present only under SEQ_PAUSE_EN.
REQ-010 busy  output  1  high whenever phase != IDLE.
REQ-011 phase  output  2  current state: IDLE=0, A=1, B=2, C=3.
REQ-012 tick  output  1  one-cycle pulse at each prescaler wrap while busy.
REQ-013 done  output  1  one-cycle pulse on completion of phase C.

Function
REQ-014 The FSM SHALL have four states, IDLE, A, B and C, and SHALL be registered; all outputs SHALL be registered.
REQ-015 In IDLE with start=1 and abort=0 at edge k, the block SHALL latch dur_a/b/c, set phase=A and busy=1 after edge k, and clear the prescaler and tick counters to 0.
REQ-016 Start SHALL be ignored while busy; latched durations SHALL NOT change mid-sequence.
REQ-017 Prescaler: 0..DIV-1 counter incremented every cycle while busy; tick=1 for the cycle following the edge at which the count wraps from DIV-1 to 0, so the first tick lands DIV cycles after start acceptance.
REQ-018 Tick counter: 8-bit count of ticks in the current phase; on a tick with count == dur_x-1, the FSM SHALL advance A->B->C and reset the count to 0; otherwise the count SHALL increment.
REQ-019 A latched duration of 0 SHALL be treated as 1 tick; phase x SHALL therefore last exactly max(dur_x,1)*DIV cycles.
REQ-020 At the end of C, done SHALL pulse for 1 cycle, coincident with the phase change; the next state SHALL be A if loop=1 (durations re-latched from inputs, counters cleared), else IDLE.
REQ-021 abort=1 in any busy state SHALL force IDLE at the next edge, clear the counters and suppress done, even if the end of C coincides.
REQ-022 In IDLE, simultaneous start and abort SHALL leave the block in IDLE.
REQ-023 In IDLE the prescaler and tick counters SHALL hold at 0, and tick and done SHALL be 0.

Reset
REQ-024 rst=1 SHALL override all other inputs at the edge.
REQ-025 On reset, the block SHALL set phase=IDLE, busy=0, tick=0, done=0, all counters 0 and latched durations 0.
REQ-026 Reset asserted mid-sequence SHALL abort the sequence without a done pulse; the block SHALL accept start on the first cycle after rst falls.

Configuration
REQ-027 Macro SEQ_PAUSE_EN: when defined, port pause SHALL exist, and pause=1 while busy SHALL freeze the prescaler, tick counter and FSM, with tick forced to 0; abort and rst SHALL still take effect while paused.
REQ-028 Without SEQ_PAUSE_EN, the pause port and its logic SHALL be absent, and timing SHALL be identical to pause held at 0.

Verification (CLK_HZ=10, TICK_HZ=1, DIV=10)
REQ-029 Basic sequence: dur=2/3/1, start pulse at cycle 0 -> phase=1 for cycles 1-20, 2 for 21-50, 3 for 51-60; done pulses at the exit of C; busy=0 from cycle 61.
REQ-030 Zero duration: dur_a=0, dur_b=1, dur_c=1 -> phase A lasts 10 cycles; total busy time is 30 cycles.
REQ-031 Loop: loop=1, dur=1/1/1 -> done pulses every 30 cycles, and phase returns to 1 with no IDLE gap.
REQ-032 Abort: abort asserted at cycle 25 of the basic sequence -> phase=0 at the next edge, and no done pulse.
REQ-033 Start while busy: start re-pulsed at cycle 15 with new durations -> timing is unchanged from the basic sequence.
REQ-034 Pause (SEQ_PAUSE_EN defined): pause held high for 7 cycles during phase B -> the end of B, and all later events, shift by exactly 7 cycles.
